// File: rtl/alu_pwr_ctrl.sv
// alu_pwr_ctrl: always-on power sequencer for the ALU domain.
// Drives the power-switch enable, isolation clamp and domain reset through a
// fixed, glitch-free down/up sequence, and gates ALU starts outside ON.
// Optional feature: define ALU_AUTO_PD_EN to enable idle-based automatic
// power-down and start-triggered power-up.
module alu_pwr_ctrl #(
    parameter int ISO_SETUP_CYC = 2,
    parameter int RAMP_CYC      = 8,
    parameter int ISO_HOLD_CYC  = 2,
    parameter int IDLE_CYC      = 64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pwr_down_req_i,
    input  logic       pwr_up_req_i,
    input  logic       alu_busy_i,
    input  logic       start_in_i,
    output logic       start_out_o,
    output logic       alu_pwr_en_o,
    output logic       iso_en_o,
    output logic       alu_dom_rst_n_o,
    output logic [2:0] pwr_state_o,
    output logic       down_done_o,
    output logic       up_done_o
);

    localparam int MAX_A   = (ISO_SETUP_CYC > RAMP_CYC) ? ISO_SETUP_CYC : RAMP_CYC;
    localparam int MAX_CYC = (MAX_A > ISO_HOLD_CYC) ? MAX_A : ISO_HOLD_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    typedef enum logic [2:0] {
        ST_ON        = 3'd0,
        ST_ISO_SETUP = 3'd1,
        ST_OFF       = 3'd2,
        ST_RAMP      = 3'd3,
        ST_ISO_HOLD  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pwr_en_q, pwr_en_d;
    logic             iso_q, iso_d;
    logic             dom_rst_n_q, dom_rst_n_d;
    logic             down_done_q, down_done_d;
    logic             up_done_q, up_done_d;
    logic             down_go;
    logic             up_go;

`ifdef ALU_AUTO_PD_EN
    localparam int IDLE_W = $clog2(IDLE_CYC) + 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              idle_hit;

    // Idle counter runs only in ON, clears on any ALU activity and saturates at the trigger value
    always_comb begin
        idle_d = '0;
        if (state_q == ST_ON && !start_in_i && !alu_busy_i) begin
            idle_d = (idle_q == IDLE_LAST) ? idle_q : idle_q + IDLE_W'(1);
        end
    end

    // Idle counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    // A start in the same cycle as the idle trigger wins so it is never forwarded into a dying domain
    always_comb begin
        idle_hit = (idle_q == IDLE_LAST) && !start_in_i;
        down_go  = (pwr_down_req_i || idle_hit) && !alu_busy_i;
        up_go    = pwr_up_req_i || start_in_i;
    end
`else
    // Power transitions come only from the explicit request lines
    always_comb begin
        down_go = pwr_down_req_i && !alu_busy_i;
        up_go   = pwr_up_req_i;
    end
`endif

    // Next-state and registered-output decode; outputs hold unless a transition changes them
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pwr_en_d    = pwr_en_q;
        iso_d       = iso_q;
        dom_rst_n_d = dom_rst_n_q;
        down_done_d = 1'b0;
        up_done_d   = 1'b0;
        case (state_q)
            ST_ON: begin
                if (down_go) begin
                    state_d = ST_ISO_SETUP;
                    iso_d   = 1'b1;
                    cnt_d   = CNT_W'(ISO_SETUP_CYC - 1);
                end
            end
            ST_ISO_SETUP: begin
                if (cnt_q == '0) begin
                    state_d     = ST_OFF;
                    pwr_en_d    = 1'b0;
                    dom_rst_n_d = 1'b0;
                    down_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_OFF: begin
                if (up_go) begin
                    state_d  = ST_RAMP;
                    pwr_en_d = 1'b1;
                    cnt_d    = CNT_W'(RAMP_CYC - 1);
                end
            end
            ST_RAMP: begin
                if (cnt_q == '0) begin
                    state_d     = ST_ISO_HOLD;
                    dom_rst_n_d = 1'b1;
                    cnt_d       = CNT_W'(ISO_HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ISO_HOLD: begin
                if (cnt_q == '0) begin
                    state_d   = ST_ON;
                    iso_d     = 1'b0;
                    up_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d     = ST_ON;
                cnt_d       = '0;
                pwr_en_d    = 1'b1;
                iso_d       = 1'b0;
                dom_rst_n_d = 1'b1;
            end
        endcase
    end

    // State, counter and power-control registers; reset aborts any sequence and lands in ON
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_ON;
            cnt_q       <= '0;
            pwr_en_q    <= 1'b1;
            iso_q       <= 1'b0;
            dom_rst_n_q <= 1'b1;
            down_done_q <= 1'b0;
            up_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pwr_en_q    <= pwr_en_d;
            iso_q       <= iso_d;
            dom_rst_n_q <= dom_rst_n_d;
            down_done_q <= down_done_d;
            up_done_q   <= up_done_d;
        end
    end

    // Starts reach the ALU only while the domain is fully on
    always_comb begin
        start_out_o = start_in_i && (state_q == ST_ON);
    end

    assign alu_pwr_en_o    = pwr_en_q;
    assign iso_en_o        = iso_q;
    assign alu_dom_rst_n_o = dom_rst_n_q;
    assign pwr_state_o     = state_q;
    assign down_done_o     = down_done_q;
    assign up_done_o       = up_done_q;

endmodule

// File: tb/tb_alu_pwr_ctrl.sv
// tb_alu_pwr_ctrl: scoreboard bench for alu_pwr_ctrl.
// Expected per-cycle output vectors are queued when a request is driven and
// compared on the falling edge once the DUT reaches that cycle.
// Build with ALU_AUTO_PD_EN defined to exercise the auto power-down path.
module tb_alu_pwr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwrDownReq = 1'b0;
    logic       pwrUpReq = 1'b0;
    logic       aluBusy = 1'b0;
    logic       startIn = 1'b0;
    logic       startOut;
    logic       aluPwrEn;
    logic       isoEn;
    logic       aluDomRstN;
    logic [2:0] pwrState;
    logic       downDone;
    logic       upDone;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int         cyc;
        string      tag;
        logic [8:0] vec;
    } exp_t;

    exp_t expQ[$];

    alu_pwr_ctrl dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .pwr_down_req_i  (pwrDownReq),
        .pwr_up_req_i    (pwrUpReq),
        .alu_busy_i      (aluBusy),
        .start_in_i      (startIn),
        .start_out_o     (startOut),
        .alu_pwr_en_o    (aluPwrEn),
        .iso_en_o        (isoEn),
        .alu_dom_rst_n_o (aluDomRstN),
        .pwr_state_o     (pwrState),
        .down_done_o     (downDone),
        .up_done_o       (upDone)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Count rising edges so expectations can be tied to absolute cycles
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Vector layout: {state[2:0], pwr_en, iso_en, dom_rst_n, down_done, up_done, start_out}
    function automatic logic [8:0] obsVec();
        return {pwrState, aluPwrEn, isoEn, aluDomRstN, downDone, upDone, startOut};
    endfunction

    task automatic pushExp(input int c, input string tag, input logic [2:0] st, input logic [5:0] flags);
        exp_t e;
        e.cyc = c;
        e.tag = tag;
        e.vec = {st, flags};
        expQ.push_back(e);
    endtask

    task automatic pushRange(input int c0, input int c1, input string tag, input logic [2:0] st, input logic [5:0] flags);
        for (int c = c0; c <= c1; c++) pushExp(c, tag, st, flags);
    endtask

    task automatic applyStimulus(input logic down, input logic up, input logic busy, input logic start);
        pwrDownReq = down;
        pwrUpReq   = up;
        aluBusy    = busy;
        startIn    = start;
    endtask

    // Ordering invariants every cycle, then drain all expectations due by this cycle
    always @(negedge clk) begin
        exp_t e;
        checkOutput("order", {30'd0, !isoEn && (!aluPwrEn || !aluDomRstN), aluDomRstN && !aluPwrEn}, 32'd0);
        while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
            e = expQ.pop_front();
            if (e.cyc != cyc) checkOutput({e.tag, "_missed"}, cyc, e.cyc);
            else checkOutput(e.tag, {23'd0, obsVec()}, {23'd0, e.vec});
        end
    end

    initial begin
        int n;
        int k;
        int m;

`ifdef ALU_AUTO_PD_EN
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("rst_async", {23'd0, obsVec()}, {23'd0, 3'd0, 6'b101000});
        rst_n = 1'b1;
        n = cyc;
        pushRange(n + 1, n + 63, "auto_idle", 3'd0, 6'b101000);
        pushExp(n + 64, "auto_iso", 3'd1, 6'b111000);
        pushExp(n + 65, "auto_setup", 3'd1, 6'b111000);
        pushExp(n + 66, "auto_off", 3'd2, 6'b010100);
        pushExp(n + 67, "auto_off_hold", 3'd2, 6'b010000);
        repeat (70) @(negedge clk);
        m = cyc + 1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        pushExp(m, "auto_wake", 3'd3, 6'b110000);
        pushExp(m + 10, "auto_up_done", 3'd0, 6'b101010);
        pushExp(m + 11, "auto_on", 3'd0, 6'b101000);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
`else
        // Reset state
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("rst_async", {23'd0, obsVec()}, {23'd0, 3'd0, 6'b101001});
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t1_on", {23'd0, obsVec()}, {23'd0, 3'd0, 6'b101001});

        // Power-down pulse with ALU idle
        k = cyc + 1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        pushExp(k, "t2_iso", 3'd1, 6'b111000);
        pushExp(k + 1, "t2_setup", 3'd1, 6'b111000);
        pushExp(k + 2, "t2_off", 3'd2, 6'b010100);
        pushExp(k + 3, "t2_done_end", 3'd2, 6'b010000);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);

        // Power-up from OFF
        m = cyc + 1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        pushRange(m, m + 7, "t3_ramp", 3'd3, 6'b110000);
        pushRange(m + 8, m + 9, "t3_hold", 3'd4, 6'b111000);
        pushExp(m + 10, "t3_up_done", 3'd0, 6'b101011);
        pushExp(m + 11, "t3_on", 3'd0, 6'b101001);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (12) @(negedge clk);

        // Down request waits while busy, then starts on the first idle edge
        n = cyc;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        pushRange(n + 1, n + 20, "t4_busy", 3'd0, 6'b101001);
        repeat (20) @(negedge clk);
        k = cyc + 1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        pushExp(k, "t4_iso", 3'd1, 6'b111000);
        pushExp(k + 2, "t4_off", 3'd2, 6'b010100);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // Async reset in the middle of RAMP
        m = cyc + 1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        pushRange(m, m + 3, "t5_ramp", 3'd3, 6'b110000);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("t5_async_rst", {23'd0, obsVec()}, {23'd0, 3'd0, 6'b101001});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t5_after_rst", {23'd0, obsVec()}, {23'd0, 3'd0, 6'b101001});

        // Both requests held: down acted on in ON, up acted on in OFF, up ignored back in ON
        k = cyc + 1;
        m = k + 3;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        pushRange(k, k + 1, "t6_setup", 3'd1, 6'b111000);
        pushExp(k + 2, "t6_off", 3'd2, 6'b010100);
        pushRange(m, m + 7, "t6_ramp", 3'd3, 6'b110000);
        pushRange(m + 8, m + 9, "t6_hold", 3'd4, 6'b111000);
        pushExp(m + 10, "t6_up_done", 3'd0, 6'b101011);
        pushExp(m + 11, "t6_on_held", 3'd0, 6'b101001);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (12) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
`endif

        for (int i = 0; i < 200 && expQ.size() > 0; i++) @(negedge clk);
        if (expQ.size() > 0) checkOutput("drain", expQ.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
